// File: rtl/gardner_timing_ctrl.sv
// Gardner timing-recovery sequencer: modulo-1 NCO strobe scheduler with fractional
// interval output, plus an IDLE/ACQ/TRACK/HOLD mode FSM that selects loop gain and reports lock.
`timescale 1ns/1ps
module gardner_timing_ctrl #(
  parameter int               NCO_W    = 16,
  parameter int               ERR_W    = 16,
  parameter logic [NCO_W-1:0] NOM_STEP = 16'h8000,
  parameter int               MU_SHIFT = 1,
  parameter logic [ERR_W-1:0] LOCK_THR = 16'd2048,
  parameter int               LOCK_N   = 8,
  parameter int               MISS_N   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [ERR_W-1:0] loop_adj,
  input  logic [ERR_W-1:0] ted_err,
  input  logic             err_valid,
  input  logic             freeze,
  output logic             strobe,
  output logic             sym_strobe,
  output logic [NCO_W-1:0] mu,
  output logic             gain_sel,
  output logic             locked,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ACQ   = 2'b01;
  localparam logic [1:0] S_TRACK = 2'b10;
  localparam logic [1:0] S_HOLD  = 2'b11;

  localparam int SW  = ((NCO_W > ERR_W) ? NCO_W : ERR_W) + 2;
  localparam int LCW = $clog2(LOCK_N + 1);
  localparam int MCW = $clog2(MISS_N + 1);
  localparam int MW  = NCO_W + MU_SHIFT;

  logic [NCO_W-1:0] eta_reg;
  logic             phase_reg;
  logic [LCW-1:0]   lock_cnt_reg, lock_cnt_next, lock_inc;
  logic [MCW-1:0]   miss_cnt_reg, miss_cnt_next, miss_inc;
  logic [1:0]       state_reg, state_next;
  logic             saved_track_reg, saved_track_next;

  logic [SW-1:0]    step_sum;
  logic [NCO_W-1:0] step_adj, step;
  logic             nco_run, underflow;
  logic [MW-1:0]    mu_wide;
  logic [NCO_W-1:0] mu_sat;
  logic [ERR_W-1:0] err_mag;
  logic             good_sym;

  assign state = state_reg;

  // Step is NOM_STEP plus the signed loop correction, clamped so the NCO always advances.
  always_comb begin
    step_sum = SW'(NOM_STEP) + {{(SW-ERR_W){loop_adj[ERR_W-1]}}, loop_adj};
    if (step_sum[SW-1] || step_sum == '0)
      step_adj = NCO_W'(1);
    else if ((step_sum >> NCO_W) != '0)
      step_adj = '1;
    else
      step_adj = step_sum[NCO_W-1:0];
  end

  assign step      = (state_reg == S_HOLD || freeze) ? NOM_STEP : step_adj;
  assign nco_run   = in_valid && (state_reg != S_IDLE);
  assign underflow = nco_run && (eta_reg < step);
  assign mu_wide   = MW'(eta_reg) << MU_SHIFT;
  assign mu_sat    = ((mu_wide >> NCO_W) != '0) ? '1 : mu_wide[NCO_W-1:0];

  // The most negative error has no positive twin, so it folds onto the largest magnitude.
  always_comb begin
    if (!ted_err[ERR_W-1])
      err_mag = ted_err;
    else if (ted_err == {1'b1, {(ERR_W-1){1'b0}}})
      err_mag = {1'b0, {(ERR_W-1){1'b1}}};
    else
      err_mag = -ted_err;
  end

  assign good_sym = (err_mag < LOCK_THR);
  assign lock_inc = (lock_cnt_reg == LCW'(LOCK_N)) ? lock_cnt_reg : lock_cnt_reg + 1'b1;
  assign miss_inc = (miss_cnt_reg == MCW'(MISS_N)) ? miss_cnt_reg : miss_cnt_reg + 1'b1;

  always_comb begin
    state_next       = state_reg;
    saved_track_next = saved_track_reg;
    lock_cnt_next    = lock_cnt_reg;
    miss_cnt_next    = miss_cnt_reg;
    if (!en) begin
      state_next       = S_IDLE;
      saved_track_next = 1'b0;
      lock_cnt_next    = '0;
      miss_cnt_next    = '0;
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_ACQ;
        S_ACQ, S_TRACK: begin
          if (freeze) begin
            state_next       = S_HOLD;
            saved_track_next = (state_reg == S_TRACK);
          end else if (err_valid) begin
            if (good_sym) begin
              lock_cnt_next = lock_inc;
              miss_cnt_next = '0;
            end else begin
              lock_cnt_next = '0;
              miss_cnt_next = miss_inc;
            end
            if (state_reg == S_ACQ && good_sym && lock_inc == LCW'(LOCK_N)) begin
              state_next    = S_TRACK;
              lock_cnt_next = '0;
              miss_cnt_next = '0;
            end else if (state_reg == S_TRACK && !good_sym && miss_inc == MCW'(MISS_N)) begin
              state_next    = S_ACQ;
              lock_cnt_next = '0;
              miss_cnt_next = '0;
            end
          end
        end
        default: if (!freeze) state_next = saved_track_reg ? S_TRACK : S_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      eta_reg         <= '1;
      phase_reg       <= 1'b0;
      lock_cnt_reg    <= '0;
      miss_cnt_reg    <= '0;
      state_reg       <= S_IDLE;
      saved_track_reg <= 1'b0;
      strobe          <= 1'b0;
      sym_strobe      <= 1'b0;
      mu              <= '0;
      gain_sel        <= 1'b0;
      locked          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      saved_track_reg <= saved_track_next;
      lock_cnt_reg    <= lock_cnt_next;
      miss_cnt_reg    <= miss_cnt_next;
      gain_sel        <= (state_next == S_TRACK) || (state_next == S_HOLD && saved_track_next);
      locked          <= (state_next == S_TRACK) || (state_next == S_HOLD && saved_track_next);
      // Disabling drops any strobe that the current sample would have produced.
      if (!en) begin
        eta_reg    <= '1;
        phase_reg  <= 1'b0;
        strobe     <= 1'b0;
        sym_strobe <= 1'b0;
      end else begin
        strobe     <= underflow;
        sym_strobe <= underflow && phase_reg;
        if (nco_run) eta_reg <= eta_reg - step;
        if (underflow) begin
          mu        <= mu_sat;
          phase_reg <= ~phase_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_gardner_timing_ctrl.sv
// Directed bench for gardner_timing_ctrl: hand-computed strobe/mu/state vectors per scenario.
`timescale 1ns/1ps
module tb_gardner_timing_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ACQ   = 2'b01;
  localparam logic [1:0] S_TRACK = 2'b10;
  localparam logic [1:0] S_HOLD  = 2'b11;

  logic        clk = 1'b0;
  logic        reset, en, in_valid, err_valid, freeze;
  logic [15:0] loop_adj, ted_err;
  logic        strobe, sym_strobe, gain_sel, locked;
  logic [15:0] mu;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  gardner_timing_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .loop_adj(loop_adj),
    .ted_err(ted_err), .err_valid(err_valid), .freeze(freeze), .strobe(strobe),
    .sym_strobe(sym_strobe), .mu(mu), .gain_sel(gain_sel), .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b0; en = 1'b0; in_valid = 1'b0; err_valid = 1'b0; freeze = 1'b0;
    loop_adj = 16'h0; ted_err = 16'h0;
    tick();
    reset = 1'b1; en = 1'b1;
    tick();
    vectors++;
    if (state !== S_ACQ) begin
      miscompares++;
      $display("FAIL restart_state: got %0d expected %0d", state, S_ACQ);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; in_valid = 1'b1; err_valid = 1'b1; freeze = 1'b0;
    loop_adj = 16'h0; ted_err = 16'h0;
    repeat (3) tick();
    vectors++;
    if (state !== S_IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE);
    end
    vectors++;
    if ({strobe, sym_strobe, mu, gain_sel, locked} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got strobe=%b sym=%b mu=%h gain=%b locked=%b expected all zero",
               strobe, sym_strobe, mu, gain_sel, locked);
    end
    $display("reset: state=%0d strobe=%b mu=%h", state, strobe, mu);
  endtask

  task automatic test_nominal();
    restart();
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic exp_st, exp_sym;
      tick();
      exp_st  = (k % 2 == 0);
      exp_sym = (k % 4 == 0);
      vectors++;
      if ({strobe, sym_strobe} !== {exp_st, exp_sym}) begin
        miscompares++;
        $display("FAIL nominal_strobe[%0d]: got %b%b expected %b%b", k, strobe, sym_strobe, exp_st, exp_sym);
      end
      if (exp_st) begin
        vectors++;
        if (mu !== 16'hFFFE) begin
          miscompares++;
          $display("FAIL nominal_mu[%0d]: got %h expected fffe", k, mu);
        end
      end
      $display("nominal sample %0d: strobe=%b sym=%b mu=%h", k, strobe, sym_strobe, mu);
    end
    vectors++;
    if (state !== S_ACQ) begin
      miscompares++;
      $display("FAIL nominal_state: got %0d expected %0d", state, S_ACQ);
    end
  endtask

  task automatic test_adjust();
    bit          st_tab  [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0};
    bit          sym_tab [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0};
    logic [15:0] mu_tab  [12] = '{16'h0, 16'hDFFE, 16'h0, 16'h9FFE, 16'h0, 16'h5FFE,
                                  16'h0, 16'h1FFE, 16'hFFFE, 16'h0, 16'hBFFE, 16'h0};
    restart();
    in_valid = 1'b1; loop_adj = 16'h1000;
    for (int k = 0; k < 12; k++) begin
      tick();
      vectors++;
      if ({strobe, sym_strobe} !== {st_tab[k], sym_tab[k]}) begin
        miscompares++;
        $display("FAIL adjust_strobe[%0d]: got %b%b expected %b%b", k, strobe, sym_strobe, st_tab[k], sym_tab[k]);
      end
      if (st_tab[k]) begin
        vectors++;
        if (mu !== mu_tab[k]) begin
          miscompares++;
          $display("FAIL adjust_mu[%0d]: got %h expected %h", k, mu, mu_tab[k]);
        end
      end
      $display("adjust sample %0d: strobe=%b sym=%b mu=%h", k, strobe, sym_strobe, mu);
    end
  endtask

  task automatic test_lock();
    restart();
    ted_err = 16'd100;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_state;
      err_valid = 1'b1;
      tick();
      exp_state = (i == 7) ? S_TRACK : S_ACQ;
      vectors++;
      if ({state, locked, gain_sel} !== {exp_state, (i == 7), (i == 7)}) begin
        miscompares++;
        $display("FAIL lock_acq[%0d]: got state=%0d locked=%b gain=%b expected state=%0d",
                 i, state, locked, gain_sel, exp_state);
      end
      $display("lock good %0d: state=%0d locked=%b", i, state, locked);
      err_valid = 1'b0;
      tick();
    end
    ted_err = 16'h8000;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_state;
      err_valid = 1'b1;
      tick();
      exp_state = (i == 3) ? S_ACQ : S_TRACK;
      vectors++;
      if ({state, locked, gain_sel} !== {exp_state, (i != 3), (i != 3)}) begin
        miscompares++;
        $display("FAIL lock_miss[%0d]: got state=%0d locked=%b gain=%b expected state=%0d",
                 i, state, locked, gain_sel, exp_state);
      end
      $display("lock miss %0d: state=%0d locked=%b", i, state, locked);
      err_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_threshold();
    restart();
    for (int i = 0; i < 16; i++) begin
      logic [1:0] exp_state;
      ted_err   = (i < 7) ? 16'hF801 : (i == 7) ? 16'h0800 : 16'h07FF;
      err_valid = 1'b1;
      tick();
      exp_state = (i == 15) ? S_TRACK : S_ACQ;
      vectors++;
      if (state !== exp_state) begin
        miscompares++;
        $display("FAIL threshold[%0d]: got %0d expected %0d (ted_err=%h)", i, state, exp_state, ted_err);
      end
      $display("threshold %0d: ted_err=%h state=%0d", i, ted_err, state);
    end
    err_valid = 1'b0;
  endtask

  task automatic test_freeze();
    restart();
    ted_err = 16'd100; err_valid = 1'b1;
    repeat (8) tick();
    err_valid = 1'b0;
    vectors++;
    if (state !== S_TRACK) begin
      miscompares++;
      $display("FAIL freeze_pre_track: got %0d expected %0d", state, S_TRACK);
    end
    in_valid = 1'b1; freeze = 1'b1; loop_adj = 16'h7FFF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if ({state, locked, gain_sel, strobe, sym_strobe} !== {S_HOLD, 1'b1, 1'b1, (k % 2 == 0), (k == 4)}) begin
        miscompares++;
        $display("FAIL freeze_hold[%0d]: got state=%0d locked=%b gain=%b strobe=%b sym=%b",
                 k, state, locked, gain_sel, strobe, sym_strobe);
      end
      if (k % 2 == 0) begin
        vectors++;
        if (mu !== 16'hFFFE) begin
          miscompares++;
          $display("FAIL freeze_mu[%0d]: got %h expected fffe", k, mu);
        end
      end
      $display("hold sample %0d: state=%0d strobe=%b mu=%h", k, state, strobe, mu);
    end
    freeze = 1'b0; loop_adj = 16'h0; in_valid = 1'b0;
    tick();
    vectors++;
    if ({state, locked} !== {S_TRACK, 1'b1}) begin
      miscompares++;
      $display("FAIL freeze_release_track: got state=%0d locked=%b expected 2/1", state, locked);
    end
    // Freeze out of ACQ, with symbols arriving that must not be counted.
    restart();
    freeze = 1'b1; err_valid = 1'b1; ted_err = 16'd100;
    repeat (8) tick();
    vectors++;
    if ({state, locked, gain_sel} !== {S_HOLD, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL freeze_acq_hold: got state=%0d locked=%b gain=%b expected 3/0/0", state, locked, gain_sel);
    end
    freeze = 1'b0; err_valid = 1'b0;
    tick();
    vectors++;
    if (state !== S_ACQ) begin
      miscompares++;
      $display("FAIL freeze_release_acq: got %0d expected %0d", state, S_ACQ);
    end
    err_valid = 1'b1;
    repeat (7) tick();
    err_valid = 1'b0;
    vectors++;
    if (state !== S_ACQ) begin
      miscompares++;
      $display("FAIL freeze_no_count: got %0d expected %0d", state, S_ACQ);
    end
    $display("freeze from acq: state=%0d", state);
  endtask

  task automatic test_disable();
    restart();
    in_valid = 1'b1;
    tick();
    en = 1'b0;
    tick();
    vectors++;
    if ({state, strobe} !== {S_IDLE, 1'b0}) begin
      miscompares++;
      $display("FAIL disable_idle: got state=%0d strobe=%b expected 0/0", state, strobe);
    end
    en = 1'b1;
    tick();
    vectors++;
    if ({state, strobe} !== {S_ACQ, 1'b0}) begin
      miscompares++;
      $display("FAIL disable_reenable: got state=%0d strobe=%b expected 1/0", state, strobe);
    end
    tick();
    vectors++;
    if (strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_first_sample: got strobe=%b expected 0", strobe);
    end
    tick();
    vectors++;
    if ({strobe, sym_strobe, mu} !== {1'b1, 1'b0, 16'hFFFE}) begin
      miscompares++;
      $display("FAIL disable_second_sample: got strobe=%b sym=%b mu=%h expected 1/0/fffe", strobe, sym_strobe, mu);
    end
    $display("disable: re-enabled strobe=%b mu=%h", strobe, mu);
  endtask

  task automatic test_step_floor();
    bit vld_tab [6] = '{1, 0, 1, 0, 1, 0};
    bit st_tab  [6] = '{0, 0, 0, 0, 1, 0};
    restart();
    in_valid = 1'b1; loop_adj = 16'h7FFE;
    tick();
    loop_adj = 16'h8000;
    for (int k = 0; k < 6; k++) begin
      in_valid = vld_tab[(k + 1) % 6];
      tick();
      vectors++;
      if (strobe !== st_tab[(k + 1) % 6]) begin
        miscompares++;
        $display("FAIL floor_strobe[%0d]: got %b expected %b", k, strobe, st_tab[(k + 1) % 6]);
      end
      if (st_tab[(k + 1) % 6]) begin
        vectors++;
        if ({sym_strobe, mu} !== {1'b0, 16'h0000}) begin
          miscompares++;
          $display("FAIL floor_mu[%0d]: got sym=%b mu=%h expected 0/0000", k, sym_strobe, mu);
        end
      end
      $display("floor cycle %0d: in_valid=%b strobe=%b mu=%h", k, in_valid, strobe, mu);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_adjust();
    test_lock();
    test_threshold();
    test_freeze();
    test_disable();
    test_step_floor();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
